multicycle_controller: RTL

- Moore-style control FSM that sequences the multi-cycle MIPS datapath: instruction fetch, decode, execute, memory and writeback.
- Drives all datapath write enables and mux selects, the ALU operation, and the immediate extender mode (sign vs zero extension of instr[15:0]).
- Sits beside the datapath. Reads opcode/funct from the instruction register and zero from the ALU.
- Handshakes with a variable-latency memory through mem_ready.

---
 rtl/mips_ctrl_pkg.sv | 95 +++++++++
 rtl/alu_decoder.sv | 88 ++++++++
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared encodings for the multi-cycle MIPS control path:
//     - state_t      : control FSM states
//     - alu_class_t  : what kind of ALU use the current state makes; this
//                      selects the decoding done by alu_decoder
//     - opcode / funct constants for the supported instruction subset
//     - alu_ctrl codes, ALU B-source and PC-source encodings
//     - decode_next(): DECODE dispatch from opcode to the first execute state
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC_R,
        ALUWB,
        EXEC_I,
        IWB,
        BRANCH,
        JUMP
    } state_t;

    // ALU usage class of the current state.
    typedef enum logic [2:0] {
        CLS_NONE,    // ALU unused: alu_ctrl 000, ext_op 0
        CLS_FETCH,   // PC + 4
        CLS_ADDR,    // address / branch-target add with sign-extended imm
        CLS_RTYPE,   // operation taken from funct
        CLS_ITYPE,   // operation taken from opcode
        CLS_BRANCH   // compare by subtraction
    } alu_class_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // First state after DECODE. Unsupported opcodes return to FETCH; the
    // controller flags them as illegal in the same DECODE cycle.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:                          nxt = EXEC_R;
            OP_LW, OP_SW:                      nxt = MEMADR;
            OP_BEQ, OP_BNE:                    nxt = BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = EXEC_I;
            OP_J:                              nxt = JUMP;
            default:                           nxt = FETCH;
        endcase
        return nxt;
    endfunction

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return decode_next(op) != FETCH;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
//   Purely combinational ALU control decode.
//   Ports:
//     cls           in   ALU usage class of the current FSM state
//     opcode        in   instr[31:26]
//     funct         in   instr[5:0]
//     alu_ctrl      out  ALU operation (010 add, 110 sub, 000 and, 001 or,
//                        111 slt)
//     ext_op        out  immediate extender mode, 1 = sign, 0 = zero
//     funct_illegal out  high when cls is R-type and funct is unsupported
// ---------------------------------------------------------------------------
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_class_t  cls,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_ctrl,
    output logic        ext_op,
    output logic        funct_illegal
);

    always_comb begin
        alu_ctrl      = ALU_AND;
        ext_op        = 1'b0;
        funct_illegal = 1'b0;

        case (cls)
            CLS_FETCH: begin
                alu_ctrl = ALU_ADD;
            end

            CLS_ADDR: begin
                alu_ctrl = ALU_ADD;
                ext_op   = 1'b1;
            end

            CLS_BRANCH: begin
                alu_ctrl = ALU_SUB;
                ext_op   = 1'b1;
            end

            CLS_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end

            CLS_ITYPE: begin
                // Logical immediates are zero-extended, arithmetic and
                // compare immediates are sign-extended.
                case (opcode)
                    OP_ADDI: begin
                        alu_ctrl = ALU_ADD;
                        ext_op   = 1'b1;
                    end
                    OP_SLTI: begin
                        alu_ctrl = ALU_SLT;
                        ext_op   = 1'b1;
                    end
                    OP_ANDI: begin
                        alu_ctrl = ALU_AND;
                        ext_op   = 1'b0;
                    end
                    OP_ORI: begin
                        alu_ctrl = ALU_OR;
                        ext_op   = 1'b0;
                    end
                    default: begin
                        // Not reachable: only I-type ALU opcodes enter EXEC_I.
                        alu_ctrl = ALU_ADD;
                        ext_op   = 1'b1;
                    end
                endcase
            end

            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Moore-style control FSM for the multi-cycle MIPS datapath. Sequences
//   FETCH / DECODE / execute / memory / writeback and drives every datapath
//   enable and select. The state register is the only flop; outputs are
//   decoded combinationally from state, opcode, funct, zero and (in the
//   memory states) mem_ready.
//
//   Memory handshake: mem_req is held high in FETCH, MEMRD and MEMWR until
//   the cycle in which mem_ready is high; that cycle completes the access and
//   the FSM advances. mem_ready is ignored in every other state.
//
//   Ports:
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     opcode, funct  instruction fields from the IR
//     zero           ALU zero flag (branch resolution)
//     mem_ready      memory access completes this cycle
//     mem_req, iord, mem_write        memory request / address sel / store
//     ir_write, pc_en, pc_src         IR load, PC load, PC source
//     reg_dst, mem_to_reg, reg_write  register-file write controls
//     alu_src_a, alu_src_b, alu_ctrl  ALU operand selects and operation
//     ext_op         immediate extender mode (1 = sign, 0 = zero)
//     instr_done     pulse on the last cycle of every instruction
//     illegal_op     pulse when an unsupported opcode/funct is decoded
// ---------------------------------------------------------------------------
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       ext_op,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state;
    alu_class_t alu_cls;
    logic       funct_illegal;

    alu_decoder u_alu_decoder (
        .cls           (alu_cls),
        .opcode        (opcode),
        .funct         (funct),
        .alu_ctrl      (alu_ctrl),
        .ext_op        (ext_op),
        .funct_illegal (funct_illegal)
    );

    // -----------------------------------------------------------------------
    // State register and transitions. Reset is asynchronous, so asserting
    // rst_n mid-instruction forces S_RESET at once and every output drops
    // to zero in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= FETCH;
                FETCH:   if (mem_ready) state <= DECODE;
                DECODE:  state <= decode_next(opcode);
                MEMADR:  state <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (mem_ready) state <= MEMWB;
                MEMWR:   if (mem_ready) state <= FETCH;
                // funct_illegal is meaningful here because EXEC_R selects
                // the R-type decode class.
                EXEC_R:  state <= funct_illegal ? FETCH : ALUWB;
                EXEC_I:  state <= IWB;
                MEMWB,
                ALUWB,
                IWB,
                BRANCH,
                JUMP:    state <= FETCH;
                default: state <= S_RESET;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Everything not set by a state stays 0.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PCSRC_ALU;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        alu_cls    = CLS_NONE;

        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_cls   = CLS_FETCH;
                // IR and PC (PC + 4) load only on the completing cycle.
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end

            DECODE: begin
                // Precompute the branch target PC + (simm << 2) in ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                alu_cls   = CLS_ADDR;
                if (!is_legal_opcode(opcode)) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end

            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_cls   = CLS_ADDR;
            end

            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end

            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end

            MEMWR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end

            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_cls   = CLS_RTYPE;
                if (funct_illegal) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end

            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end

            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_cls   = CLS_ITYPE;
            end

            IWB: begin
                // alu_ctrl / ext_op stay at their EXEC_I values.
                reg_write  = 1'b1;
                alu_cls    = CLS_ITYPE;
                instr_done = 1'b1;
            end

            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_cls    = CLS_BRANCH;
                pc_src     = PCSRC_ALUOUT;
                pc_en      = (opcode == OP_BNE) ? !zero : zero;
                instr_done = 1'b1;
            end

            JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule
